// File: rtl/node_link_arbiter.sv
// Round-robin N/E/S/W link arbiter feeding one valid/ready aggregation stream.
// Optional per-link saturating grant counters when NODE_ARB_STATS_EN is defined.
package my_pkg;
    localparam int PACKET_LENGTH = 32;
endpackage

module node_link_arbiter #(
    parameter int PW = my_pkg::PACKET_LENGTH,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [PW-1:0] n_in,
    input  logic signed [PW-1:0] e_in,
    input  logic signed [PW-1:0] s_in,
    input  logic signed [PW-1:0] w_in,
    input  logic                 n_valid_in,
    input  logic                 e_valid_in,
    input  logic                 s_valid_in,
    input  logic                 w_valid_in,
    output logic                 is_reading_n,
    output logic                 is_reading_e,
    output logic                 is_reading_s,
    output logic                 is_reading_w,
    output logic signed [PW-1:0] agg_data,
    output logic [1:0]           agg_src,
    output logic                 agg_valid,
    input  logic                 agg_ready,
    output logic                 busy
`ifdef NODE_ARB_STATS_EN
    ,
    input  logic                 stats_clr,
    output logic [CNT_W-1:0]     grant_cnt_n,
    output logic [CNT_W-1:0]     grant_cnt_e,
    output logic [CNT_W-1:0]     grant_cnt_s,
    output logic [CNT_W-1:0]     grant_cnt_w
`endif
);

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t               r_state;
    logic signed [PW-1:0] r_data;
    logic [1:0]           r_src;
    logic [1:0]           r_ptr;

    logic [3:0]           w_req;
    logic [3:0]           w_rd;
    logic                 w_found;
    logic                 w_grant;
    logic [1:0]           w_win;
    logic [1:0]           w_idx;
    logic signed [PW-1:0] w_sel_data;

    assign w_req = {w_valid_in, s_valid_in, e_valid_in, n_valid_in};

    // First requester at or after the pointer, wrapping W -> N.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = '0;
        for (int i = 0; i < 4; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_found && w_req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // A new packet may enter when the register is empty or drains this cycle.
    assign w_grant = w_found && ((r_state == S_EMPTY) || agg_ready);
    assign w_rd    = w_grant ? (4'b0001 << w_win) : 4'b0000;

    always_comb begin
        case (w_win)
            2'd0:    w_sel_data = n_in;
            2'd1:    w_sel_data = e_in;
            2'd2:    w_sel_data = s_in;
            default: w_sel_data = w_in;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
            r_data  <= '0;
            r_src   <= '0;
            r_ptr   <= '0;
        end else if (w_grant) begin
            r_state <= S_FULL;
            r_data  <= w_sel_data;
            r_src   <= w_win;
            r_ptr   <= w_win + 2'd1;
        end else if (r_state == S_FULL && agg_ready) begin
            r_state <= S_EMPTY;
        end
    end

    assign is_reading_n = w_rd[0];
    assign is_reading_e = w_rd[1];
    assign is_reading_s = w_rd[2];
    assign is_reading_w = w_rd[3];
    assign agg_data     = r_data;
    assign agg_src      = r_src;
    assign agg_valid    = (r_state == S_FULL);
    assign busy         = (r_state == S_FULL);

`ifdef NODE_ARB_STATS_EN
    logic [CNT_W-1:0] r_cnt [4];

    // Clear has priority over a coincident grant; counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (stats_clr)
                    r_cnt[i] <= '0;
                else if (w_rd[i] && r_cnt[i] != '1)
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
        end
    end

    assign grant_cnt_n = r_cnt[0];
    assign grant_cnt_e = r_cnt[1];
    assign grant_cnt_s = r_cnt[2];
    assign grant_cnt_w = r_cnt[3];
`endif

endmodule

// File: tb/tb_node_link_arbiter.sv
// Randomised scoreboard bench for node_link_arbiter with a queue-based reference model.
module tb_node_link_arbiter;
    localparam int PW = 32;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] vin = '0;
    logic [PW-1:0] din [4];
    logic agg_ready = 1'b0;
    logic rd_n, rd_e, rd_s, rd_w;
    logic signed [PW-1:0] agg_data;
    logic [1:0] agg_src;
    logic agg_valid, busy;
`ifdef NODE_ARB_STATS_EN
    logic stats_clr = 1'b0;
    logic [CW-1:0] cnt_n, cnt_e, cnt_s, cnt_w;
    int mcnt [4];
`endif

    always #5 clk = ~clk;

    node_link_arbiter #(.PW(PW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .n_in(din[0]), .e_in(din[1]), .s_in(din[2]), .w_in(din[3]),
        .n_valid_in(vin[0]), .e_valid_in(vin[1]), .s_valid_in(vin[2]), .w_valid_in(vin[3]),
        .is_reading_n(rd_n), .is_reading_e(rd_e), .is_reading_s(rd_s), .is_reading_w(rd_w),
        .agg_data(agg_data), .agg_src(agg_src), .agg_valid(agg_valid),
        .agg_ready(agg_ready), .busy(busy)
`ifdef NODE_ARB_STATS_EN
        , .stats_clr(stats_clr),
        .grant_cnt_n(cnt_n), .grant_cnt_e(cnt_e), .grant_cnt_s(cnt_s), .grant_cnt_w(cnt_w)
`endif
    );

    int errors = 0;
    int checks = 0;

    typedef struct {int src; logic [PW-1:0] data;} pkt_t;
    pkt_t exp_q [$];
    int   mptr = 0;
    bit   mfull = 0;
    logic [3:0] rd_seen = '0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    // Reference model: decides each cycle's grant from the request set and the pointer.
    always @(negedge clk) begin
        if (!rst_n) begin
            mfull = 0; mptr = 0; exp_q.delete(); rd_seen = '0;
`ifdef NODE_ARB_STATS_EN
            for (int i = 0; i < 4; i++) mcnt[i] = 0;
`endif
        end else begin
            int win;
            logic [3:0] exp_rd;
            win = -1;
            if (!mfull || agg_ready)
                for (int k = 0; k < 4; k++)
                    if (win < 0 && vin[(mptr + k) % 4]) win = (mptr + k) % 4;
            exp_rd = (win >= 0) ? 4'(1 << win) : 4'b0;
            check("is_reading", {60'b0, rd_w, rd_s, rd_e, rd_n}, {60'b0, exp_rd});
            check("agg_valid/busy", {62'b0, agg_valid, busy}, {62'b0, mfull, mfull});
            rd_seen = {rd_w, rd_s, rd_e, rd_n};
`ifdef NODE_ARB_STATS_EN
            check("grant_cnt", {48'b0, cnt_w, cnt_s, cnt_e, cnt_n},
                  {48'b0, 4'(mcnt[3]), 4'(mcnt[2]), 4'(mcnt[1]), 4'(mcnt[0])});
            for (int i = 0; i < 4; i++) begin
                if (stats_clr) mcnt[i] = 0;
                else if (win == i && mcnt[i] < (1 << CW) - 1) mcnt[i]++;
            end
`endif
            if (win >= 0) begin
                exp_q.push_back('{src: win, data: din[win]});
                mptr = (win + 1) % 4;
                mfull = 1;
            end else if (mfull && agg_ready) begin
                mfull = 0;
            end
        end
    end

    // Monitor: every completed handshake must match the oldest expected packet.
    always @(negedge clk) begin
        if (rst_n && agg_valid && agg_ready) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard: handshake with no expected packet at %0t", $time);
            end else begin
                pkt_t p;
                p = exp_q.pop_front();
                check("agg_data", {32'b0, agg_data}, {32'b0, p.data});
                check("agg_src", {62'b0, agg_src}, 64'(p.src));
            end
        end
    end

    // Advance one cycle; links that were read drop, or present a fresh packet when refill is set.
    task automatic step(input bit refill);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++)
            if (rd_seen[i]) begin
                if (refill) din[i] = $urandom; else vin[i] = 1'b0;
            end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) din[i] = '0;
        #12;
        @(negedge clk); #1;
        check("reset agg_data", {32'b0, agg_data}, 64'd0);
        check("reset agg_src/valid/busy", {60'b0, agg_src, agg_valid, busy}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single N packet of value 5.
        din[0] = 32'd5; vin[0] = 1'b1; agg_ready = 1'b1;
        repeat (4) step(0);

        // All links streaming: strict N,E,S,W rotation at full rate.
        vin = 4'hF;
        for (int i = 0; i < 4; i++) din[i] = $urandom;
        repeat (8) step(1);
        vin = '0;
        repeat (3) step(0);

        // Stall: output full, ready low, E waiting.
        din[0] = $urandom; vin[0] = 1'b1;
        step(0);
        agg_ready = 1'b0; din[1] = 32'hE0E0_0001; vin[1] = 1'b1;
        repeat (5) step(0);
        agg_ready = 1'b1;
        repeat (3) step(0);

        // Randomised traffic with random backpressure and occasional withdrawals.
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) begin
                if (!vin[i] && $urandom_range(0, 1)) begin vin[i] = 1'b1; din[i] = $urandom; end
                else if (vin[i] && $urandom_range(0, 15) == 0) vin[i] = 1'b0;
            end
            agg_ready = ($urandom_range(0, 3) != 0);
        end

        // Reset while holding a packet under backpressure.
        vin = '0; agg_ready = 1'b1;
        step(0); step(0);
        vin[2] = 1'b1; din[2] = $urandom; agg_ready = 1'b0;
        step(0); step(0);
        #2 rst_n = 1'b0;
        #1;
        check("async reset agg_valid/busy", {62'b0, agg_valid, busy}, 64'd0);
        vin = 4'hF; agg_ready = 1'b1;
        for (int i = 0; i < 4; i++) din[i] = $urandom;
        step(0);
        rst_n = 1'b1;
        repeat (6) step(1);
        vin = '0;
        repeat (3) step(0);

`ifdef NODE_ARB_STATS_EN
        vin[0] = 1'b1; din[0] = $urandom; agg_ready = 1'b1;
        repeat (20) step(1);
        vin = '0;
        repeat (2) step(0);
        check("cnt_n saturated", {60'b0, cnt_n}, 64'd15);
        check("cnt_e/s/w zero", {52'b0, cnt_e, cnt_s, cnt_w}, 64'd0);
        vin[0] = 1'b1;
        stats_clr = 1'b1;
        step(1);
        stats_clr = 1'b0; vin = '0;
        #1;
        check("cnt after clear", {48'b0, cnt_w, cnt_s, cnt_e, cnt_n}, 64'd0);
        repeat (3) step(0);
`endif

        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: %0d packets never delivered, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/node_link_arbiter.md
Name: node_link_arbiter

Overview:
- Round-robin arbiter in front of a mesh node's single aggregation input.
- Accepts packets offered on the four neighbour links (N, E, S, W) and serialises them into one valid/ready stream toward the node's aggregation datapath.
- Returns per-link is_reading_* accept pulses to the neighbours.
- Tags each forwarded packet with its source direction so the aggregator can route partial results.

Parameters:
- PW, PACKET_LENGTH (from my_pkg): packet width in bits.
- CNT_W, 16: width of the per-link grant counters (optional feature only).

Ports:
- clk  in  1  single clock for the block.
- rst_n  in  1  asynchronous active-low reset.
- n_in, e_in, s_in, w_in  in  PW each  signed packets from neighbours.
- n_valid_in, e_valid_in, s_valid_in, w_valid_in  in  1 each  neighbour holds a valid packet; stays asserted until accepted.
- is_reading_n, is_reading_e, is_reading_s, is_reading_w  out  1 each  one-cycle accept pulse; the neighbour drops or advances its packet on the next edge.
- agg_data  out  PW  forwarded packet (signed).
- agg_src  out  2  source of agg_data: 0=N, 1=E, 2=S, 3=W.
- agg_valid  out  1  agg_data/agg_src are valid.
- agg_ready  in  1  aggregator accepts on a cycle where agg_valid && agg_ready.
- busy  out  1  output register holds a packet.

Behaviour:
- Reset (async, rst_n=0):
  - agg_data=0, agg_src=0, agg_valid=0, busy=0, all is_reading_*=0.
  - Round-robin pointer = N (0).
  - Counters cleared.
- State machine, one output register:
  - EMPTY: agg_valid=0.
  - FULL: agg_valid=1, register contents stable until the handshake completes.
- Transitions:
  - EMPTY → FULL when any valid_in is high. Grant winner; capture its packet and direction; pulse its is_reading_* in the same cycle. agg_valid rises on the next cycle (latency 1 cycle from valid_in to agg_valid).
  - FULL, agg_ready=1, some valid_in high: stay FULL. Load the next winner in the same cycle (back-to-back). Sustained throughput is 1 packet/cycle.
  - FULL, agg_ready=1, no valid_in: → EMPTY.
  - FULL, agg_ready=0: stay FULL. No is_reading_* pulses.
- Arbitration:
  - Fixed order N, E, S, W, searched starting at the pointer.
  - After a grant, pointer = winner+1 (mod 4, W wraps to N).
  - Pointer changes only on a grant.
- At most one is_reading_* high in any cycle. is_reading_x never pulses while x_valid_in=0.
- A neighbour whose valid_in stays high receives a grant within 4 accepted packets (no starvation).
- Data is passed bit-exact; no arithmetic or sign change.
- busy mirrors agg_valid.
- Reset asserted mid-transfer: the held packet is discarded, agg_valid drops immediately (async), and the pointer returns to N.
- valid_in deasserting without a grant is allowed; that request is simply not considered.

Optional Feature:
- Macro: NODE_ARB_STATS_EN.
- Defined:
  - Adds outputs grant_cnt_n/e/s/w, each CNT_W bits.
  - Each counter increments on its link's is_reading_* pulse and saturates at all-ones (no wrap).
  - Adds input stats_clr (1 bit): synchronously clears all four counters. If stats_clr coincides with a grant, the clear wins and the counter reads 0.
- Not defined: these ports and counters do not exist; arbitration is identical.

Test Plan:
- Reset, then n_valid_in=1, n_in=0x0000_0005, agg_ready=1
  → is_reading_n pulses in cycle 0.
  → Cycle 1: agg_valid=1, agg_data=5, agg_src=0.
  → Cycle 2: agg_valid=0 once n_valid_in has dropped.
- All four valid_in held high, agg_ready=1 for 8 cycles
  → grant order N, E, S, W, N, E, S, W.
  → agg_src sequence 0,1,2,3,0,1,2,3, with agg_valid continuously high from cycle 1.
- Output held FULL with agg_ready=0 for 5 cycles while e_valid_in=1
  → agg_data stable, no is_reading_e.
  → When agg_ready=1, is_reading_e pulses that same cycle and agg_src=1 the next cycle.
- Pointer at S (last grant E), only w_valid_in and n_valid_in high
  → W granted first, then N.
- Assert rst_n=0 mid-stream while FULL with agg_ready=0
  → agg_valid=0 immediately without waiting for clk.
  → After release, first grant goes to N when all links are valid.
- NODE_ARB_STATS_EN defined, CNT_W=4, 20 N grants
  → grant_cnt_n=15 (saturated), others 0.
  → stats_clr pulse → all counters 0.
